// File: rtl/rockets_pkg.sv
// Shared types, default geometry and colour for the player rocket controller.
package rockets_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        FLYING = 1'b1
    } slot_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 11;

    localparam int DEF_ROCKET_W     = 4;
    localparam int DEF_ROCKET_H     = 16;
    localparam int DEF_SPEED        = 8;
    localparam int DEF_LAUNCH_Y     = 440;
    localparam int DEF_LAUNCH_X_OFS = 14;
    localparam int DEF_COOLDOWN     = 15;
    localparam logic [7:0] DEF_ROCKET_COLOR = 8'hFC;

    // Half-open span test done one bit wider so a rocket near 2047 never wraps.
    function automatic logic in_span(input logic [COORD_W-1:0] pos,
                                     input logic [COORD_W-1:0] lo,
                                     input int                 len);
        logic [COORD_W:0] p;
        logic [COORD_W:0] l;
        p = {1'b0, pos};
        l = {1'b0, lo};
        return (p >= l) && (p < l + (COORD_W+1)'(len));
    endfunction

endpackage

// File: rtl/player_rockets_ctrl_if.sv
// Pixel scan in, per-slot drawing requests and colours out toward the objects mux.
interface player_rockets_ctrl_if;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic [1:0]  p_rockets_DR;
    logic [7:0]  p_rocket0_RGB;
    logic [7:0]  p_rocket1_RGB;

    modport master (
        input  pixelX, pixelY,
        output p_rockets_DR, p_rocket0_RGB, p_rocket1_RGB
    );

    modport slave (
        output pixelX, pixelY,
        input  p_rockets_DR, p_rocket0_RGB, p_rocket1_RGB
    );
endinterface

// File: rtl/player_rocket_slot.sv
// One rocket slot: flight state, position, and registered drawing request/colour.
//   state  | meaning
//   IDLE   | slot free, nothing drawn, may be launched at startOfFrame
//   FLYING | rocket on screen, climbs SPEED pixels per frame
module player_rocket_slot
    import rockets_pkg::*;
#(
    parameter int         ROCKET_W     = DEF_ROCKET_W,
    parameter int         ROCKET_H     = DEF_ROCKET_H,
    parameter int         SPEED        = DEF_SPEED,
    parameter int         LAUNCH_Y     = DEF_LAUNCH_Y,
    parameter logic [7:0] ROCKET_COLOR = DEF_ROCKET_COLOR
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               launch,
    input  logic               collision,
    input  logic [COORD_W-1:0] launch_x,
    input  logic [COORD_W-1:0] pixelX,
    input  logic [COORD_W-1:0] pixelY,
    output logic               flying,
    output logic               dr,
    output logic [7:0]         rgb
);
    localparam logic [COORD_W-1:0] SPEED_C    = COORD_W'(SPEED);
    localparam logic [COORD_W-1:0] LAUNCH_Y_C = COORD_W'(LAUNCH_Y);

    slot_state_t        state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               hit;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Retirement is decided before subtracting because y is unsigned.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = FLYING;
                    x_d     = launch_x;
                    y_d     = LAUNCH_Y_C;
                end
            end
            FLYING: begin
                if (collision) begin
                    state_d = IDLE;
                end else if (startOfFrame) begin
                    if (y_q < SPEED_C) state_d = IDLE;
                    else               y_d = y_q - SPEED_C;
                end
            end
        endcase
    end

    // A slot leaving FLYING stops drawing on the very next cycle.
    assign hit = (state_q == FLYING) && (state_d == FLYING)
               && in_span(pixelX, x_q, ROCKET_W)
               && in_span(pixelY, y_q, ROCKET_H);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            dr  <= 1'b0;
            rgb <= 8'h00;
        end else begin
            dr  <= hit;
            rgb <= hit ? ROCKET_COLOR : 8'h00;
        end
    end

    assign flying = (state_q == FLYING);

endmodule

// File: rtl/player_rockets_ctrl.sv
// Player rocket controller: fire sync/edge detect, cooldown, slot arbitration, two slots.
module player_rockets_ctrl
    import rockets_pkg::*;
#(
    parameter int         ROCKET_W     = DEF_ROCKET_W,
    parameter int         ROCKET_H     = DEF_ROCKET_H,
    parameter int         SPEED        = DEF_SPEED,
    parameter int         LAUNCH_Y     = DEF_LAUNCH_Y,
    parameter int         LAUNCH_X_OFS = DEF_LAUNCH_X_OFS,
    parameter int         COOLDOWN     = DEF_COOLDOWN,
    parameter logic [7:0] ROCKET_COLOR = DEF_ROCKET_COLOR
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         startOfFrame,
    input  logic                         fireKey,
    input  logic [10:0]                  playerX,
    input  logic [1:0]                   collision,
    player_rockets_ctrl_if.master        draw,
    output logic                         firedPulse
);
    localparam int             CD_W       = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [CD_W-1:0] COOLDOWN_C = CD_W'(COOLDOWN);

    logic            fire_sync, fire_prev, fire_pending;
    logic [CD_W-1:0] cooldown_cnt;
    logic [1:0]      flying, launch, dr;
    logic [7:0]      rgb [2];
    logic            launch_ok;
    logic [10:0]     launch_x;

    assign launch_x  = playerX + 11'(LAUNCH_X_OFS);
    assign launch_ok = startOfFrame && fire_pending && (cooldown_cnt == '0) && !(&flying);
    // Slot 0 wins when both are free.
    assign launch[0] = launch_ok && !flying[0];
    assign launch[1] = launch_ok &&  flying[0] && !flying[1];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fire_sync    <= 1'b0;
            fire_prev    <= 1'b0;
            fire_pending <= 1'b0;
            cooldown_cnt <= '0;
            firedPulse   <= 1'b0;
        end else begin
            fire_sync <= fireKey;
            fire_prev <= fire_sync;
            // A press lives for at most one frame boundary.
            if (startOfFrame)                fire_pending <= 1'b0;
            else if (fire_sync && !fire_prev) fire_pending <= 1'b1;
            if (launch_ok)
                cooldown_cnt <= COOLDOWN_C;
            else if (startOfFrame && (cooldown_cnt != '0))
                cooldown_cnt <= cooldown_cnt - CD_W'(1);
            firedPulse <= launch_ok;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_slot
        player_rocket_slot #(
            .ROCKET_W     (ROCKET_W),
            .ROCKET_H     (ROCKET_H),
            .SPEED        (SPEED),
            .LAUNCH_Y     (LAUNCH_Y),
            .ROCKET_COLOR (ROCKET_COLOR)
        ) u_slot (
            .clk          (clk),
            .resetN       (resetN),
            .startOfFrame (startOfFrame),
            .launch       (launch[i]),
            .collision    (collision[i]),
            .launch_x     (launch_x),
            .pixelX       (draw.pixelX),
            .pixelY       (draw.pixelY),
            .flying       (flying[i]),
            .dr           (dr[i]),
            .rgb          (rgb[i])
        );
    end

    assign draw.p_rockets_DR  = dr;
    assign draw.p_rocket0_RGB = rgb[0];
    assign draw.p_rocket1_RGB = rgb[1];

endmodule

// File: doc/player_rockets_ctrl.md
# player_rockets_ctrl

Owns the player's two rocket slots. It latches fire requests, launches a rocket from the player's current X, and moves active rockets upward once per frame. It retires rockets at the top of the screen or on a collision report. Each pixel cycle it produces the per-slot drawing requests and RGB values that the objects mux consumes as its player-rocket inputs (`p_rockets_DR[1:0]`, `p_rocket0_RGB`, `p_rocket1_RGB`).

## Interface
Parameters:
- `ROCKET_W`, 4: rocket width in pixels
- `ROCKET_H`, 16: rocket height in pixels
- `SPEED`, 8: upward pixels moved per frame
- `LAUNCH_Y`, 440: top-Y of a newly launched rocket
- `LAUNCH_X_OFS`, 14: added to `playerX` to get the rocket's left X
- `COOLDOWN`, 15: minimum number of frames between launches
- `ROCKET_COLOR`, 8'hFC: RGB332 fill colour

Ports:
- `clk`  in  1  pixel clock
- `resetN`  in  1  asynchronous, active-low reset
- `startOfFrame`  in  1  one-cycle pulse at frame start
- `fireKey`  in  1  level; synchronous to `clk`
- `playerX`  in  11  player left X
- `pixelX`  in  11  current scan X
- `pixelY`  in  11  current scan Y
- `collision`  in  2  per-slot hit pulse, where bit i refers to slot i
- `p_rockets_DR`  out  2  per-slot drawing request
- `p_rocket0_RGB`  out  8  slot 0 colour
- `p_rocket1_RGB`  out  8  slot 1 colour
- `firedPulse`  out  1  one-cycle pulse on each launch (sound/score hook)

## Operation
Slot state machine, one per slot, with states IDLE and FLYING:
- IDLE -> FLYING on launch.
- FLYING -> IDLE on `collision[i]`.
- FLYING -> IDLE at `startOfFrame` when `y < SPEED`. The `y` field is unsigned, so retirement is decided by this compare before any subtraction.
- Otherwise, at `startOfFrame`, `y <= y - SPEED`.

Fire path:
- `fireKey` is registered once. A rising edge sets `firePending`.
- At `startOfFrame`, a launch happens only if all three hold: `firePending` = 1, `cooldownCnt` = 0, and at least one slot is IDLE.
- Slot 0 has priority when both slots are IDLE.
- A launch loads `x <= playerX + LAUNCH_X_OFS` (11-bit, wraps modulo 2048) and `y <= LAUNCH_Y`.
- A launch reloads `cooldownCnt <= COOLDOWN` and pulses `firedPulse`.
- `firePending` clears at every `startOfFrame`, whether or not a launch occurred. A press is therefore never queued beyond one frame.
- `cooldownCnt` decrements at each `startOfFrame` while non-zero and saturates at 0.
- At a given `startOfFrame`, movement of FLYING slots applies only to slots that were FLYING before that edge. A newly launched slot does not move in its launch frame.

Simultaneous events:
- `collision[i]` and `startOfFrame` in the same cycle: the collision wins and the slot goes IDLE. That slot cannot be relaunched in the same cycle.
- `collision[i]` while slot i is IDLE is ignored.

Drawing:
- `DR[i] = FLYING_i && x_i <= pixelX < x_i + ROCKET_W && y_i <= pixelY < y_i + ROCKET_H`.
- Comparisons use 12-bit sums, so no wrap occurs in the window test.
- `RGB_i` = `ROCKET_COLOR` when `DR[i]`, else 8'h00.

## Timing
- Reset values: `p_rockets_DR` = 0, both RGB = 0, `firedPulse` = 0, slots IDLE, `x`/`y` = 0, `cooldownCnt` = 0, `firePending` = 0, fire-sync register = 0.
- DR and RGB are registered: one-cycle latency from `pixelX`/`pixelY`. The objects mux adds one more cycle, so the pixel counters feeding downstream must be aligned for two cycles.
- A slot entering IDLE drops its DR from the next cycle onward.
- State updates happen on the `startOfFrame` cycle. Drawing uses the new position from the following cycle.
- `fireKey` to `firePending`: two cycles (sync register plus edge detect).
- `resetN` asserted mid-frame: all state clears immediately. After release, a rocket only appears after a new press and the next `startOfFrame`.

## Structure
- Package `rockets_pkg`: `slot_state_t` enum (IDLE, FLYING), screen constants (640×480), default geometry, default colour.
- Sub-module `player_rocket_slot`: one per slot, containing the state, `x`/`y`, the window compare and the registered DR/RGB.
- Top level: fire sync and edge detect, cooldown counter, slot arbiter, and two slot instances.

## Test plan
- Reset, then frames with no stimulus -> DR = 00 and RGB = 0 everywhere.
- `playerX` = 100, press fire, wait one `startOfFrame` -> slot 0 FLYING at x = 114, y = 440; `firedPulse` high for one cycle. The scan at (114..117, 440..455) gives `DR[0]` = 1 one cycle later; (118, 440) gives 0.
- Press again 5 frames later -> no launch (cooldown). Press at 16 frames -> slot 1 launches, slot 0 keeps moving. A third press while both are FLYING -> ignored, `firePending` clears.
- Slot 0 at y = 8: next frame y = 0, still FLYING. The frame after, it goes IDLE and DR = 0.
- `collision` = 01 on the same cycle as `startOfFrame` with a fire pending and slot 1 FLYING -> slot 0 IDLE, no launch, slot 1 moves.
- Assert `resetN` mid-flight during active scan -> DR/RGB = 0 on the same edge. No rocket appears after release without a new press.
